// File: rtl/four_bit_comparator.sv
// Registered magnitude comparator with cascade input, one compare per cycle.
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        synchronous active-low reset
//   in_valid     A, B, cas_in and signed_mode are valid this cycle
//   signed_mode  0 = unsigned compare, 1 = two's-complement compare
//   A, B         operands, WIDTH bits each
//   cas_in       one-hot relation from the less-significant slice (3'b010 when unused)
//   R            registered one-hot relation: R[2]=A>B, R[1]=A==B, R[0]=A<B
//   out_valid    R holds the result of the compare accepted on the previous edge
module four_bit_comparator #(
  parameter int unsigned WIDTH       = 4,
  parameter logic [2:0]  CAS_DEFAULT = 3'b010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cas_in,
  output logic [2:0]       R,
  output logic             out_valid
);

  localparam logic [2:0] REL_GT = 3'b100;
  localparam logic [2:0] REL_EQ = 3'b010;
  localparam logic [2:0] REL_LT = 3'b001;

  logic       cas_onehot_c;
  logic [2:0] cas_sel_c;
  logic [2:0] rel_c;
  logic       decided_c;
  logic       a_wins_c;

  // A malformed cascade code is replaced so R stays strictly one-hot.
  always_comb begin
    cas_onehot_c = (cas_in == REL_GT) || (cas_in == REL_EQ) || (cas_in == REL_LT);
    cas_sel_c    = cas_onehot_c ? cas_in : CAS_DEFAULT;
  end

  // MSB-first scan: the first differing bit decides. In signed mode the sign
  // bit has inverted weight, so a set MSB on A makes A the smaller operand.
  always_comb begin
    decided_c = 1'b0;
    a_wins_c  = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (!decided_c && (A[i] != B[i])) begin
        decided_c = 1'b1;
        a_wins_c  = A[i] ^ (signed_mode & (i == int'(WIDTH) - 1));
      end
    end
    rel_c = cas_sel_c;
    if (decided_c) begin
      rel_c = a_wins_c ? REL_GT : REL_LT;
    end
  end

  // Output stage: R only updates on a valid compare, otherwise it holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      R         <= 3'b000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        R <= rel_c;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_comparator.sv
// Scoreboard bench for four_bit_comparator: directed vectors plus random traffic.
module tb_four_bit_comparator;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       cas_in;
  logic [2:0]       R;
  logic             out_valid;

  typedef struct {
    logic       v;
    logic [2:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  four_bit_comparator #(.WIDTH(WIDTH), .CAS_DEFAULT(3'b010)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .signed_mode(signed_mode),
    .A          (A),
    .B          (B),
    .cas_in     (cas_in),
    .R          (R),
    .out_valid  (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: compare operands as plain integers.
  function automatic logic [2:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic sm, input logic [2:0] cas);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    if (sm) begin
      if (ia >= (1 << (WIDTH - 1))) ia = ia - (1 << WIDTH);
      if (ib >= (1 << (WIDTH - 1))) ib = ib - (1 << WIDTH);
    end
    if (ia > ib) return 3'b100;
    if (ia < ib) return 3'b001;
    if ($countones(cas) == 1) return cas;
    return 3'b010;
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus side of the scoreboard: record what each accepted edge should produce.
  always @(posedge clk) begin
    exp_t e;
    if (rst_n) begin
      e.v = in_valid;
      e.r = in_valid ? model(A, B, signed_mode, cas_in) : 3'b000;
      exp_q.push_back(e);
    end
  end

  // Monitor: shortly after each edge compare the DUT outputs with the scoreboard.
  logic [2:0] held_r;
  always @(posedge clk) begin
    logic rs;
    exp_t e;
    rs = rst_n;
    #1;
    if (!rs) begin
      check("reset_out_valid", {2'b00, out_valid}, 3'b000);
      check("reset_R", R, 3'b000);
      held_r = 3'b000;
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      check("scoreboard_empty", 3'b111, 3'b000);
    end else begin
      e = exp_q.pop_front();
      check("out_valid", {2'b00, out_valid}, {2'b00, e.v});
      if (e.v) begin
        check("R_result", R, e.r);
        held_r = e.r;
      end else begin
        check("R_hold", R, held_r);
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] cas,
                      input logic sm, input logic v);
    @(negedge clk);
    A           = a;
    B           = b;
    cas_in      = cas;
    signed_mode = sm;
    in_valid    = v;
  endtask

  initial begin
    logic [3:0] eqv [4];
    logic [2:0] casv [3];
    eqv  = '{4'b1110, 4'b1111, 4'b1000, 4'b0000};
    casv = '{3'b010, 3'b100, 3'b011};

    rst_n       = 1'b0;
    in_valid    = 1'b1;
    signed_mode = 1'b0;
    A           = 4'b0001;
    B           = 4'b0000;
    cas_in      = 3'b010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // A < B back to back
    send(4'b0100, 4'b1010, 3'b010, 1'b0, 1'b1);
    send(4'b1100, 4'b1111, 3'b010, 1'b0, 1'b1);
    send(4'b0010, 4'b1101, 3'b010, 1'b0, 1'b1);
    send(4'b0011, 4'b1101, 3'b010, 1'b0, 1'b1);

    // A == B with good, overriding and malformed cascade codes
    foreach (casv[c]) begin
      foreach (eqv[k]) send(eqv[k], eqv[k], casv[c], 1'b0, 1'b1);
    end

    // A > B, then a signed compare where the sign bit flips the answer
    send(4'b0001, 4'b0000, 3'b010, 1'b0, 1'b1);
    send(4'b1111, 4'b1110, 3'b010, 1'b0, 1'b1);
    send(4'b0101, 4'b0011, 3'b010, 1'b0, 1'b1);
    send(4'b0010, 4'b0001, 3'b010, 1'b0, 1'b1);
    send(4'b1000, 4'b0111, 3'b010, 1'b1, 1'b1);
    send(4'b0000, 4'b0001, 3'b010, 1'b0, 1'b1);

    // Gap: R must hold while in_valid is low and operands wander
    send(4'b1100, 4'b1111, 3'b010, 1'b0, 1'b1);
    send(4'b0111, 4'b0001, 3'b100, 1'b0, 1'b0);
    send(4'b1111, 4'b1111, 3'b100, 1'b1, 1'b0);
    send(4'b0000, 4'b1000, 3'b001, 1'b0, 1'b0);

    // Reset mid-stream drops the in-flight result
    send(4'b1001, 4'b0001, 3'b010, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, cascade code drawn from all eight values
    for (int n = 0; n < 1000; n++) begin
      send(4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    send(4'b0000, 4'b0000, 3'b010, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
